// File: rtl/alu_serial_ctrl_if.sv
// CPU-side request/response bundle for the bit-serial ALU sequencer.
// The master issues operands and control; the slave returns status and results.
interface alu_serial_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [3:0]       ALU_control_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             cout_o;
    logic             overflow_o;

    modport master (
        output start_i,
        output src1_i,
        output src2_i,
        output ALU_control_i,
        input  busy_o,
        input  done_o,
        input  result_o,
        input  zero_o,
        input  cout_o,
        input  overflow_o
    );

    modport slave (
        input  start_i,
        input  src1_i,
        input  src2_i,
        input  ALU_control_i,
        output busy_o,
        output done_o,
        output result_o,
        output zero_o,
        output cout_o,
        output overflow_o
    );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer driving one external 1-bit slice, LSB first.
// Optional abort_i input is enabled by defining ALU_SERIAL_ABORT_EN.
module alu_serial_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic       clk_i,
    input  logic       rst_i,
`ifdef ALU_SERIAL_ABORT_EN
    input  logic       abort_i,
`endif
    alu_serial_ctrl_if.slave bus,
    output logic       slice_src1_o,
    output logic       slice_src2_o,
    output logic       slice_A_invert_o,
    output logic       slice_B_invert_o,
    output logic       slice_cin_o,
    output logic       slice_less_o,
    output logic [1:0] slice_op_o,
    input  logic       slice_result_i,
    input  logic       slice_cout_i,
    input  logic       slice_set_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_SLT_FIX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_ainv;
    logic             r_binv;
    logic [1:0]       r_op;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_cout_l;
    logic             r_ovf_l;
    logic             r_set_msb;
    logic             r_cout;
    logic             r_ovf;

    logic w_accept;
    logic w_last;
    logic w_abort;
    logic w_is_slt;
    logic w_bit_ovf;

    assign w_accept  = (r_state == S_IDLE) && bus.start_i;
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_is_slt  = (r_op == 2'd3);
    assign w_bit_ovf = r_carry ^ slice_cout_i;

`ifdef ALU_SERIAL_ABORT_EN
    assign w_abort = abort_i &&
                     ((r_state == S_RUN) || (r_state == S_SLT_FIX));
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start_i) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_abort) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = w_is_slt ? S_SLT_FIX : S_DONE;
                end
            end
            S_SLT_FIX: begin
                w_next = w_abort ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Flags are loaded on the edge entering DONE so they are valid with done_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_a       <= '0;
            r_b       <= '0;
            r_ainv    <= 1'b0;
            r_binv    <= 1'b0;
            r_op      <= 2'd0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_cout_l  <= 1'b0;
            r_ovf_l   <= 1'b0;
            r_set_msb <= 1'b0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_accept) begin
            r_a      <= bus.src1_i;
            r_b      <= bus.src2_i;
            r_ainv   <= bus.ALU_control_i[3];
            r_binv   <= bus.ALU_control_i[2];
            r_op     <= bus.ALU_control_i[1:0];
            r_carry  <= bus.ALU_control_i[2];
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_abort) begin
            r_result <= '0;
        end else if (r_state == S_RUN) begin
            r_result[r_cnt] <= slice_result_i;
            r_carry         <= slice_cout_i;
            r_cnt           <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_cout_l  <= slice_cout_i;
                r_ovf_l   <= w_bit_ovf;
                r_set_msb <= slice_set_i;
                if (!w_is_slt) begin
                    r_cout <= slice_cout_i;
                    r_ovf  <= (r_op == 2'd2) && w_bit_ovf;
                end
            end
        end else if (r_state == S_SLT_FIX) begin
            r_result[0] <= r_set_msb ^ r_ovf_l;
            r_cout      <= r_cout_l;
            r_ovf       <= 1'b0;
        end
    end

    assign slice_src1_o     = r_a[r_cnt];
    assign slice_src2_o     = r_b[r_cnt];
    assign slice_A_invert_o = r_ainv;
    assign slice_B_invert_o = r_binv;
    assign slice_cin_o      = r_carry;
    assign slice_less_o     = 1'b0;
    assign slice_op_o       = r_op;

    assign bus.busy_o     = (r_state != S_IDLE);
    assign bus.done_o     = (r_state == S_DONE);
    assign bus.result_o   = r_result;
    assign bus.zero_o     = ~|r_result;
    assign bus.cout_o     = r_cout;
    assign bus.overflow_o = r_ovf;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Scoreboard bench for alu_serial_ctrl with a behavioural 1-bit slice.
// Expected results come from a word-level arithmetic model.
module tb_alu_serial_ctrl;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
`ifdef ALU_SERIAL_ABORT_EN
    logic abort_i;
`endif

    logic       s_src1, s_src2, s_ainv, s_binv, s_cin, s_less;
    logic [1:0] s_op;
    logic       s_res, s_cout, s_set;
    logic       s_a, s_b, s_sum;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_serial_ctrl_if #(.WIDTH(W)) bus ();

    alu_serial_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
`ifdef ALU_SERIAL_ABORT_EN
        .abort_i          (abort_i),
`endif
        .bus              (bus),
        .slice_src1_o     (s_src1),
        .slice_src2_o     (s_src2),
        .slice_A_invert_o (s_ainv),
        .slice_B_invert_o (s_binv),
        .slice_cin_o      (s_cin),
        .slice_less_o     (s_less),
        .slice_op_o       (s_op),
        .slice_result_i   (s_res),
        .slice_cout_i     (s_cout),
        .slice_set_i      (s_set)
    );

    // Combinational 1-bit ALU slice
    assign s_a    = s_src1 ^ s_ainv;
    assign s_b    = s_src2 ^ s_binv;
    assign s_sum  = s_a ^ s_b ^ s_cin;
    assign s_set  = s_sum;
    assign s_cout = (s_a & s_b) | (s_a & s_cin) | (s_b & s_cin);
    assign s_res  = (s_op == 2'd0) ? (s_a & s_b) :
                    (s_op == 2'd1) ? (s_a | s_b) :
                    (s_op == 2'd2) ? s_sum : s_less;

    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic [3:0]   c);
        logic [W-1:0] ea, eb;
        logic [W:0]   s;
        logic         v;
        exp_t         e;
        ea = c[3] ? ~a : a;
        eb = c[2] ? ~b : b;
        s  = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, c[2]};
        v  = (ea[W-1] == eb[W-1]) && (s[W-1] != ea[W-1]);
        case (c[1:0])
            2'd0:    e.res = ea & eb;
            2'd1:    e.res = ea | eb;
            2'd2:    e.res = s[W-1:0];
            default: e.res = {{(W-1){1'b0}}, s[W-1] ^ v};
        endcase
        e.c   = s[W];
        e.v   = (c[1:0] == 2'd2) ? v : 1'b0;
        e.lat = (c[1:0] == 2'd3) ? W + 2 : W + 1;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] c);
        bus.src1_i        = a;
        bus.src2_i        = b;
        bus.ALU_control_i = c;
        bus.start_i       = 1'b1;
        sb.push_back(model(a, b, c));
        tick();
        bus.start_i = 1'b0;
    endtask

    // Waits for done_o starting in cycle `cyc`, then checks the popped entry.
    task automatic wait_done(input string name, input int cyc);
        int   n;
        exp_t e;
        n = cyc;
        while (bus.done_o !== 1'b1 && n < 3 * W) begin
            tick();
            n++;
        end
        checks++;
        if (bus.done_o !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: done_o not seen by cycle %0d", name, n);
            return;
        end
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: done_o with no pending entry", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (bus.result_o !== e.res) begin
            errors++;
            $display("FAIL %s result: got %h want %h", name, bus.result_o, e.res);
        end
        checks++;
        if (bus.zero_o !== (e.res == '0)) begin
            errors++;
            $display("FAIL %s zero: got %b want %b", name, bus.zero_o, e.res == '0);
        end
        checks++;
        if (bus.cout_o !== e.c) begin
            errors++;
            $display("FAIL %s cout: got %b want %b", name, bus.cout_o, e.c);
        end
        checks++;
        if (bus.overflow_o !== e.v) begin
            errors++;
            $display("FAIL %s overflow: got %b want %b", name, bus.overflow_o, e.v);
        end
        checks++;
        if (n !== e.lat) begin
            errors++;
            $display("FAIL %s latency: got cycle %0d want %0d", name, n, e.lat);
        end
        checks++;
        if (bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_in_done: got %b want 1", name, bus.busy_o);
        end
        tick();
        checks++;
        if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: got done=%b busy=%b want 0 0",
                     name, bus.done_o, bus.busy_o);
        end
    endtask

    task automatic check_reset_vals(input string name);
        checks++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL %s busy/done: got %b %b want 0 0", name, bus.busy_o, bus.done_o);
        end
        checks++;
        if (bus.result_o !== '0 || bus.zero_o !== 1'b1) begin
            errors++;
            $display("FAIL %s result/zero: got %h %b want 0 1", name, bus.result_o, bus.zero_o);
        end
        checks++;
        if (bus.cout_o !== 1'b0 || bus.overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL %s cout/ovf: got %b %b want 0 0", name, bus.cout_o, bus.overflow_o);
        end
    endtask

    task automatic test_reset();
        rst               = 1'b1;
        bus.start_i       = 1'b0;
        bus.src1_i        = '0;
        bus.src2_i        = '0;
        bus.ALU_control_i = 4'd0;
`ifdef ALU_SERIAL_ABORT_EN
        abort_i = 1'b0;
`endif
        #23;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_arith();
        issue(32'h7FFF_FFFF, 32'h0000_0001, 4'b0010);
        wait_done("add_ovf", 1);
        issue(32'd5, 32'd5, 4'b0110);
        wait_done("sub_zero", 1);
        issue(32'h1234_5678, 32'h0FED_CBA9, 4'b0110);
        wait_done("sub_mix", 1);
    endtask

    task automatic test_slt();
        issue(32'hFFFF_FFFF, 32'h0000_0001, 4'b0111);
        wait_done("slt_neg", 1);
        issue(32'h7FFF_FFFF, 32'h8000_0000, 4'b0111);
        wait_done("slt_ovf", 1);
    endtask

    task automatic test_logic();
        issue(32'h0, 32'h0, 4'b1100);
        wait_done("nor", 1);
        issue(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000);
        wait_done("and", 1);
        issue(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0001);
        wait_done("or", 1);
    endtask

    task automatic test_ignore_start();
        int dones;
        issue(32'hA5A5_A5A5, 32'h0F0F_0F0F, 4'b0000);
        for (int i = 1; i < 10; i++) tick();
        bus.src1_i        = 32'hFFFF_FFFF;
        bus.src2_i        = 32'hFFFF_FFFF;
        bus.ALU_control_i = 4'b0001;
        bus.start_i       = 1'b1;
        tick();
        bus.start_i = 1'b0;
        wait_done("ignore_start", 11);
        dones = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (bus.done_o === 1'b1) dones++;
            tick();
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL ignore_start extra_done: got %0d want 0", dones);
        end
    endtask

    task automatic test_back_to_back();
        bus.src1_i        = 32'h0000_0003;
        bus.src2_i        = 32'h0000_0004;
        bus.ALU_control_i = 4'b0010;
        bus.start_i       = 1'b1;
        sb.push_back(model(32'h3, 32'h4, 4'b0010));
        tick();
        bus.src1_i        = 32'h8000_0000;
        bus.src2_i        = 32'h0000_0001;
        bus.ALU_control_i = 4'b0111;
        sb.push_back(model(32'h8000_0000, 32'h1, 4'b0111));
        wait_done("b2b_first", 1);
        tick();
        bus.start_i = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b accept: got busy=%b want 1", bus.busy_o);
        end
        wait_done("b2b_second", 1);
    endtask

    task automatic test_async_reset();
        issue(32'h1111_1111, 32'h2222_2222, 4'b0010);
        for (int i = 1; i < 15; i++) tick();
        #3;
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        tick();
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        tick();
        issue(32'h0000_00FF, 32'h0000_0001, 4'b0010);
        wait_done("after_rst", 1);
    endtask

`ifdef ALU_SERIAL_ABORT_EN
    task automatic test_abort();
        int dones;
        issue(32'h1111_1111, 32'h2222_2222, 4'b0010);
        for (int i = 1; i < 15; i++) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        void'(sb.pop_back());
        checks++;
        if (bus.busy_o !== 1'b0 || bus.result_o !== '0) begin
            errors++;
            $display("FAIL abort state: got busy=%b res=%h want 0 0",
                     bus.busy_o, bus.result_o);
        end
        dones = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (bus.done_o === 1'b1) dones++;
            tick();
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL abort done: got %0d pulses want 0", dones);
        end
        issue(32'h0000_0010, 32'h0000_0020, 4'b0010);
        wait_done("after_abort", 1);
    endtask
`endif

    initial begin
        test_reset();
        test_arith();
        test_slt();
        test_logic();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
`ifdef ALU_SERIAL_ABORT_EN
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
- Bit-serial sequencer that computes a WIDTH-bit ALU operation by driving one external combinational 1-bit ALU slice, one bit per clock, LSB first.
- Latches the operands and the control code, steers the invert, carry and op fields into the slice, and carries the carry between cycles.
- Fixes up SLT from MSB set/overflow and reports result, zero, carry and overflow flags.
- Sits between the CPU decode/execute stage and the slice; it is the area-reduced alternative to the rippled slice array.

Parameters:
- WIDTH, 32: operand/result width in bits (≥2).
- CNT_W, 5: bit-counter width; must satisfy 2^CNT_W ≥ WIDTH.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  request; accepted only in IDLE.
- src1_i  in  WIDTH  operand A.
- src2_i  in  WIDTH  operand B.
- ALU_control_i  in  4  [3]=A_invert, [2]=B_invert (also initial carry-in), [1:0]=op (0 AND, 1 OR, 2 ADD, 3 SLT).
- busy_o  out  1  high from accept until done.
- done_o  out  1  one-cycle pulse; results valid.
- result_o  out  WIDTH  registered result.
- zero_o  out  1  result_o == 0.
- cout_o  out  1  carry out of MSB.
- overflow_o  out  1  signed overflow, ADD/SUB only.
- slice_src1_o, slice_src2_o  out  1  current operand bits.
- slice_A_invert_o, slice_B_invert_o  out  1  latched control bits.
- slice_cin_o  out  1  running carry.
- slice_less_o  out  1  always 0.
- slice_op_o  out  2  latched op.
- slice_result_i, slice_cout_i, slice_set_i  in  1  slice outputs; combinational, same cycle.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - busy_o, done_o, result_o, cout_o and overflow_o are 0.
  - zero_o is 1.
  - Bit counter, carry and latched fields are 0.
- States: IDLE, RUN, SLT_FIX, DONE.
- IDLE:
  - On start_i=1, latch src1_i, src2_i and ALU_control_i; set carry = ALU_control_i[2] and bit_cnt = 0.
  - Clear result_o; go to RUN.
  - busy_o rises the cycle after accept.
- RUN (one edge per bit):
  - result_o[bit_cnt] ← slice_result_i; carry ← slice_cout_i; bit_cnt++.
  - Slice inputs are driven from latched operands indexed by bit_cnt.
  - At bit_cnt = WIDTH-1:
    - Capture cout = slice_cout_i, ovf = slice_cin_o ^ slice_cout_i, set_msb = slice_set_i.
    - Go to SLT_FIX if op = 3, else DONE.
- SLT_FIX:
  - result_o[0] ← set_msb ^ ovf; all other bits remain 0 (the slice returned less = 0).
  - Go to DONE.
- DONE:
  - done_o = 1 for exactly this cycle; busy_o still 1.
  - cout_o ← cout.
  - overflow_o ← ovf only when op = 2; otherwise 0.
  - Go to IDLE.
- zero_o is combinational NOR of result_o. Outputs hold until the next accepted start.
- Latency: accept edge = cycle 0; done_o high in cycle WIDTH+1 (non-SLT) or WIDTH+2 (SLT).
- start_i while busy is ignored; it is not queued.
- start_i held high in the DONE cycle is not accepted; it is accepted in the following IDLE cycle.
- Operand or control changes after accept have no effect.
- Control codes are decoded by fields only; no illegal codes. For example 1100 = NOR, 0110 = SUB, 0111 = SLT.

Optional Feature:
- Macro: ALU_SERIAL_ABORT_EN.
- Defined:
  - Adds input abort_i (1 bit).
  - abort_i=1 in RUN or SLT_FIX returns to IDLE on that edge.
  - result_o clears to 0; busy_o drops; no done_o pulse.
  - abort_i in IDLE or DONE is ignored.
- Undefined:
  - The port does not exist.
  - Every accepted operation runs to DONE.

Test Plan:
- ADD (0010), A=0x7FFFFFFF, B=0x00000001 -> result 0x80000000, overflow_o=1, cout_o=0, zero_o=0; done_o in cycle 33 only.
- SUB (0110), A=5, B=5 -> result 0, zero_o=1, cout_o=1, overflow_o=0.
- SLT (0111):
  - A=0xFFFFFFFF, B=1 -> result 1; done_o in cycle 34.
  - A=0x7FFFFFFF, B=0x80000000 -> result 0 (overflow-corrected).
  - overflow_o=0 in both cases.
- NOR (1100), A=0, B=0 -> 0xFFFFFFFF; AND 0xF0F0F0F0 & 0xFF00FF00 -> 0xF000F000; OR of the same operands -> 0xFFF0FFF0.
- Start AND, then pulse start_i with new operands at cycle 10 -> ignored; first result unchanged; exactly one done_o.
- Assert rst_i asynchronously at cycle 15 of an ADD -> outputs immediately at reset values, state IDLE; a new start after release completes normally. With ALU_SERIAL_ABORT_EN, abort_i at cycle 15 -> busy_o low next cycle, no done_o.
